// File: rtl/cpu_pipe_pkg.sv
// cpu_pipe_pkg: shared ID/EX pipeline definitions (control field layout, default widths, skid states)
package cpu_pipe_pkg;
  localparam int CP_CTRL_W = 10;
  localparam int CP_DATA_W = 133;
  localparam int RW        = 0;
  localparam int ALUSRC    = 1;
  localparam int BR        = 2;
  localparam int MR        = 3;
  localparam int MW        = 4;
  localparam int M2R       = 5;
  localparam int ALUC_LSB  = 6;
  localparam int ALUC_MSB  = 9;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;
endpackage

// File: rtl/idex_skid_reg_if.sv
// idex_skid_reg_if: decode-side and execute-side handshake bundle of the ID/EX stage
interface idex_skid_reg_if #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              clr_stats;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready, clr_stats,
    input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );
  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready, clr_stats,
    output in_ready, out_valid, out_ctrl, out_data, stall_cnt
  );
endinterface

// File: rtl/idex_skid_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear that wins over increment
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/idex_skid_reg.sv
// idex_skid_reg: ID/EX pipeline register with 2-entry skid buffer, flush, bubble ctrl-zeroing
// and a saturating stall counter.
module idex_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W    = CP_DATA_W,
  parameter int                CTRL_W    = CP_CTRL_W,
  parameter logic [CTRL_W-1:0] KILL_MASK = '1,
  parameter int                CNT_W     = 16
) (
  input logic            clk,
  input logic            rst_n,
  idex_skid_reg_if.slave bus
);
  localparam int W = CTRL_W + DATA_W;
  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d, in_beat;
  logic         acc, pop, in_ready, out_valid;
  assign in_ready      = state_q != FULL;
  assign out_valid     = state_q != EMPTY;
  assign in_beat       = {bus.in_ctrl, bus.in_data};
  assign acc           = bus.in_valid && in_ready;
  assign pop           = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q[DATA_W-1:0];
  // Bubbles must never carry live write/branch/memory enables downstream
  assign bus.out_ctrl  = out_valid ? main_q[W-1:DATA_W] : main_q[W-1:DATA_W] & ~KILL_MASK;
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (acc) begin
        main_d  = in_beat;
        state_d = ONE;
      end
      ONE: begin
        if (pop && acc) main_d = in_beat;
        else if (pop) state_d = EMPTY;
        else if (acc) begin
          skid_d  = in_beat;
          state_d = FULL;
        end
      end
      FULL: if (pop) begin
        main_d  = skid_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (out_valid && !bus.out_ready),
    .clr_i (bus.clr_stats),
    .cnt_o (bus.stall_cnt)
  );
endmodule

// File: tb/tb_idex_skid_reg.sv
// tb_idex_skid_reg: directed stimulus checked every cycle against a queue model of the stage
module tb_idex_skid_reg;
  localparam int CW = 10, DW = 133, NW = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  idex_skid_reg_if #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) bus();
  idex_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;
  beat_t q[$];
  int sc = 0, errors = 0, checks = 0;
  bit live = 0;
  task automatic chk(string n, logic [DW-1:0] got, logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // Model: up to two accepted beats in order; the head is what execute sees
  always @(posedge clk) begin : model
    bit ov, ir;
    ov = q.size() > 0;
    ir = q.size() < 2;
    if (!rst_n) begin
      q.delete();
      sc = 0;
      live = 1;
    end else begin
      if (bus.clr_stats) sc = 0;
      else if (ov && !bus.out_ready && sc < (1 << NW) - 1) sc++;
      if (bus.flush) q.delete();
      else begin
        if (ov && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && ir) q.push_back('{bus.in_ctrl, bus.in_data});
      end
    end
  end
  always @(negedge clk) if (live) begin
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_ctrl", bus.out_ctrl, q.size() > 0 ? q[0].c : '0);
    chk("stall_cnt", bus.stall_cnt, sc);
    if (q.size() > 0) chk("out_data", bus.out_data, q[0].d);
  end
  initial begin
    bus.in_valid = 0; bus.in_ctrl = 0; bus.in_data = 0;
    bus.flush = 0; bus.out_ready = 1; bus.clr_stats = 0;
    step(); step();
    rst_n = 1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_ctrl", bus.out_ctrl, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    for (int i = 1; i <= 5; i++) begin
      bus.in_valid = 1; bus.in_data = DW'(i); bus.in_ctrl = CW'(i);
      step();
      chk("seq_valid", bus.out_valid, 1);
      chk("seq_data", bus.out_data, i);
      chk("seq_ready", bus.in_ready, 1);
    end
    bus.in_valid = 0;
    step();
    chk("seq_drain", bus.out_valid, 0);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 'hA; bus.in_ctrl = 'h0A;
    step();
    chk("bp_a", bus.out_data, 'hA);
    bus.in_data = 'hB; bus.in_ctrl = 'h0B;
    step();
    chk("bp_full", bus.in_ready, 0);
    chk("bp_hold", bus.out_data, 'hA);
    bus.in_valid = 0;
    step();
    chk("bp_cnt", bus.stall_cnt, 2);
    bus.out_ready = 1;
    step();
    chk("bp_b", bus.out_data, 'hB);
    step();
    chk("bp_empty", bus.out_valid, 0);
    chk("bp_cnt2", bus.stall_cnt, 2);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 1; bus.in_ctrl = 1;
    step();
    bus.in_data = 2; bus.in_ctrl = 2;
    step();
    bus.in_data = 'hC; bus.in_ctrl = 'h0C; bus.flush = 1;
    step();
    bus.flush = 0; bus.in_valid = 0;
    chk("fl_valid", bus.out_valid, 0);
    chk("fl_ctrl", bus.out_ctrl, 0);
    chk("fl_ready", bus.in_ready, 1);
    bus.out_ready = 1;
    step();
    chk("fl_no_c", bus.out_valid, 0);
    bus.in_valid = 1; bus.in_data = 3; bus.in_ctrl = 3;
    step();
    bus.in_data = 'hD; bus.in_ctrl = 'h0D; bus.flush = 1;
    step();
    bus.flush = 0; bus.in_valid = 0;
    chk("fl_one_d", bus.out_valid, 0);
    bus.in_valid = 1; bus.in_ctrl = 'h3FF; bus.in_data = 'h55;
    step();
    chk("bub_live", bus.out_ctrl, 'h3FF);
    bus.in_valid = 0;
    step();
    chk("bub_valid", bus.out_valid, 0);
    chk("bub_ctrl", bus.out_ctrl, 0);
    bus.clr_stats = 1;
    step();
    bus.clr_stats = 0;
    chk("clr_cnt", bus.stall_cnt, 0);
    bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 6; bus.in_ctrl = 6;
    step();
    bus.in_valid = 0;
    repeat (20) step();
    chk("sat_cnt", bus.stall_cnt, 15);
    bus.clr_stats = 1;
    step();
    chk("clr_wins", bus.stall_cnt, 0);
    bus.clr_stats = 0;
    step();
    chk("cnt_resume", bus.stall_cnt, 1);
    bus.in_valid = 1; bus.in_data = 8; bus.in_ctrl = 8;
    step();
    bus.in_valid = 0;
    chk("pre_rst_full", bus.in_ready, 0);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_ctrl", bus.out_ctrl, 0);
    chk("mrst_data", bus.out_data, 0);
    chk("mrst_cnt", bus.stall_cnt, 0);
    bus.out_ready = 1; bus.in_valid = 1; bus.in_data = 7; bus.in_ctrl = 7;
    step();
    chk("post_valid", bus.out_valid, 1);
    chk("post_data", bus.out_data, 7);
    bus.in_valid = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/idex_skid_reg.md
Name: idex_skid_reg

Overview:
Parametrised ID/EX pipeline register with a valid/ready handshake and a 2-entry skid buffer. It carries a decoded control vector and a data payload from decode to execute at full throughput, with one-cycle latency. It supports back-pressure (stall), flush (branch/exception kill) and bubble control-zeroing. A saturating stall counter feeds hazard/performance analysis.

Parameters:
DATA_W, 133, payload width (imme 32, addr 32, rdata1 32, rdata2 32, rd 5)
CTRL_W, 10, control width (RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUControl[3:0])
KILL_MASK, {CTRL_W{1'b1}}, ctrl bits forced to 0 whenever out_valid=0
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  decode presents a beat
in_ready  out  1  stage can accept a beat (registered, = state!=FULL)
in_ctrl  in  CTRL_W  control vector of incoming beat
in_data  in  DATA_W  payload of incoming beat
flush  in  1  kill all held and incoming beats
out_valid  out  1  execute-side beat valid
out_ready  in  1  execute accepts the beat
out_ctrl  out  CTRL_W  control vector, KILL_MASK bits zero when !out_valid
out_data  out  DATA_W  payload, don't-care when !out_valid (holds last value)
clr_stats  in  1  clear stall counter
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating

Behaviour:
- Reset is synchronous and active-low on rst_n, clocked by clk (already decided).
- Storage: main register (drives outputs) and skid register. Three states: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- Reset (rst_n=0 at posedge): state=EMPTY, out_valid=0, in_ready=1, out_ctrl=0, out_data=0, skid cleared, stall_cnt=0. Reset mid-operation drops all beats.
- Define acc = in_valid && in_ready and pop = out_valid && out_ready.
- EMPTY: acc -> main<=in, ONE.
- ONE: pop&&acc -> main<=in, stay ONE. pop&&!acc -> EMPTY. !pop&&acc -> skid<=in, FULL. Neither -> hold.
- FULL: in_ready=0. pop -> main<=skid, ONE. Otherwise hold. No beat is ever lost or duplicated.
- Latency: a beat accepted at edge N appears on out_* after edge N (one cycle) when the stage is not stalled. Throughput is 1 beat/cycle.
- in_ready is a function of registered state only; no combinational path from out_ready.
- flush (rst_n=1): next state=EMPTY, both entries invalid, out_ctrl=0. Any beat accepted in the same cycle is discarded. Flush has priority over acc and pop. in_ready=1 in the following cycle. stall_cnt is unaffected.
- Bubble: whenever out_valid=0, out_ctrl & KILL_MASK = 0, so RegWrite, MemWrite, Branch and MemRead are inert downstream. out_data keeps its last value.
- stall_cnt increments on each cycle with out_valid && !out_ready, and saturates at 2^CNT_W-1 (no wrap).
- clr_stats sets the counter to 0 and wins over increment in the same cycle.
- Control and data are captured together. A partial update is illegal.

Decomposition:
- Shared package cpu_pipe_pkg: ctrl field bit indices (RW=0, ALUSRC=1, BR=2, MR=3, MW=4, M2R=5, ALUC=9:6), default CTRL_W/DATA_W localparams, state enum {EMPTY, ONE, FULL}.
- One natural sub-module: sat_counter (CNT_W, inc, clr) for stall_cnt. The skid datapath stays inline.

Test Plan:
- Reset with out_ready=1, then in_valid and 5 consecutive beats data=1..5 -> out_valid each cycle after the first, data 1..5 in order, in_ready=1 throughout.
- Hold out_ready=0 and present beats A=0xA, B=0xB -> A on out, B in skid, in_ready=0 on the next cycle. Release out_ready -> A, then B, each for one cycle. stall_cnt equals the number of stalled cycles.
- In state FULL, assert flush with in_valid=1 (data=0xC) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xC never appears.
- Insert a bubble with in_ctrl=10'h3FF, KILL_MASK all ones, after the last beat pops -> out_valid=0 and out_ctrl=0.
- CNT_W=4, 20 stalled cycles -> stall_cnt=15 (saturated). clr_stats together with a stall -> 0 on the next cycle.
- rst_n=0 for 1 cycle while FULL -> all outputs at reset values. A subsequent beat 0x7 emerges one cycle after acceptance.
